arb8_prio_ctrl: RTL

//  8-requester arbiter/sequencer for a shared resource. Uses the team's 8-to-3

---
 rtl/arb8_prio_ctrl_if.sv | 14 +
 rtl/arb8_prio_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/arb8_prio_ctrl_if.sv
// Request/grant bundle between the eight requesters and arb8_prio_ctrl.
// `release` is a reserved word, so the owner's done strobe is carried as `rel`.
interface arb8_prio_ctrl_if;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       idle;
  logic       timeout;

  modport master (output req, rel, input gnt, gnt_idx, busy, idle, timeout);
  modport slave  (input req, rel, output gnt, gnt_idx, busy, idle, timeout);
endinterface

// File: rtl/arb8_prio_ctrl.sv
// 8-requester arbiter: priority pick, hold grant until release/req-drop or MAX_HOLD timeout.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default build is fixed priority (req[7] highest).
module arb8_prio_ctrl #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CW       = 4
) (
  input logic              clk,
  input logic              rst,
  arb8_prio_ctrl_if.slave  bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [7:0]    gnt;
  logic [2:0]    gnt_idx;
  logic          busy;
  logic          timeout;
  logic [CW-1:0] hold_cnt;
  logic [2:0]    w;
  logic          normal_exit;
  logic          forced_exit;

  assign normal_exit = !bus.req[gnt_idx] || bus.rel;
  assign forced_exit = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD));

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] rr_ptr;
  logic [2:0] probe;
  logic       found;

  // Descending search starting just below the last owner, wrapping at 0.
  always_comb begin
    w     = '0;
    found = 1'b0;
    probe = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      probe = rr_ptr - 3'd1 - 3'(k);
      if (!found && bus.req[probe]) begin
        w     = probe;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (state == GRANT && (normal_exit || forced_exit))
      rr_ptr <= gnt_idx;
  end
`else
  always_comb begin
    w = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (bus.req[i]) w = 3'(i);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req != '0) begin
            state    <= GRANT;
            gnt      <= 8'd1 << w;
            gnt_idx  <= w;
            busy     <= 1'b1;
            hold_cnt <= CW'(1);
          end
        end
        GRANT: begin
          // A normal exit on the same edge as the limit suppresses the timeout pulse.
          if (normal_exit || forced_exit) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            timeout  <= !normal_exit;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.gnt_idx = gnt_idx;
  assign bus.busy    = busy;
  assign bus.timeout = timeout;
  assign bus.idle    = (bus.req == '0);
endmodule
